// File: rtl/echo_rx_pkg.sv
// Shared types and helpers for the ultrasonic echo receiver.
package echo_rx_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_TX     = 3'd1,
        S_BLANK  = 3'd2,
        S_LISTEN = 3'd3,
        S_DONE   = 3'd4
    } rx_state_e;

    // Accepted deviation of an edge-to-edge interval from one carrier period.
    function automatic int unsigned tol_of(input int unsigned cycles_per_period);
        return cycles_per_period / 8;
    endfunction

endpackage

// File: rtl/echo_edge_qualifier.sv
// Receiver pin conditioning and echo qualification: sync, optional majority
// filter (ECHO_RX_GLITCH_FILTER_EN), rising-edge detect, period-spaced run count.
module echo_edge_qualifier
    import echo_rx_pkg::*;
#(
    parameter int unsigned CYCLES_PER_PERIOD = 1250,
    parameter int unsigned MIN_EDGES         = 4,
    parameter int unsigned TOF_W             = 24
) (
    input  logic             clk_in,
    input  logic             reset_n,
    input  logic             receiver_pin_i,
    input  logic             listen_i,
    input  logic [TOF_W-1:0] timer_i,
    output logic             detected_c_o,
    output logic [TOF_W-1:0] first_ts_o
);

    localparam int unsigned      TOL      = tol_of(CYCLES_PER_PERIOD);
    localparam int unsigned      RUN_W    = $clog2(MIN_EDGES + 1);
    localparam logic [TOF_W-1:0] IVL_MIN  = TOF_W'(CYCLES_PER_PERIOD - TOL);
    localparam logic [TOF_W-1:0] IVL_MAX  = TOF_W'(CYCLES_PER_PERIOD + TOL);
    localparam logic [RUN_W-1:0] RUN_DONE = RUN_W'(MIN_EDGES);

    logic             sync1_q, sync2_q, sig_prev_q, edge_q;
    logic             sig_c;
    logic [RUN_W-1:0] run_q, run_d;
    logic [TOF_W-1:0] first_ts_q, first_ts_d;
    logic [TOF_W-1:0] last_ts_q, last_ts_d;
    logic [TOF_W-1:0] interval_c;
    logic             in_window_c;

`ifdef ECHO_RX_GLITCH_FILTER_EN
    logic hist1_q, hist2_q, maj_q;

    // Majority over three consecutive samples drops single-cycle pulses.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            hist1_q <= 1'b0;
            hist2_q <= 1'b0;
            maj_q   <= 1'b0;
        end else begin
            hist1_q <= sync2_q;
            hist2_q <= hist1_q;
            maj_q   <= (sync2_q & hist1_q) | (sync2_q & hist2_q) | (hist1_q & hist2_q);
        end
    end

    assign sig_c = maj_q;
`else
    assign sig_c = sync2_q;
`endif

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            sig_prev_q <= 1'b0;
            edge_q     <= 1'b0;
        end else begin
            sync1_q    <= receiver_pin_i;
            sync2_q    <= sync1_q;
            sig_prev_q <= sig_c;
            edge_q     <= sig_c & ~sig_prev_q;
        end
    end

    assign interval_c  = timer_i - last_ts_q;
    assign in_window_c = (interval_c >= IVL_MIN) && (interval_c <= IVL_MAX);

    // Run tracking; a stale run is dropped once the gap exceeds one period plus tolerance.
    always_comb begin
        run_d        = run_q;
        first_ts_d   = first_ts_q;
        last_ts_d    = last_ts_q;
        detected_c_o = 1'b0;
        if (!listen_i) begin
            run_d = '0;
        end else if (edge_q) begin
            last_ts_d = timer_i;
            if ((run_q != '0) && in_window_c) begin
                run_d = run_q + RUN_W'(1);
                if (run_d == RUN_DONE) begin
                    detected_c_o = 1'b1;
                end
            end else begin
                run_d      = RUN_W'(1);
                first_ts_d = timer_i;
            end
        end else if ((run_q != '0) && (interval_c > IVL_MAX)) begin
            run_d = '0;
        end
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            run_q      <= '0;
            first_ts_q <= '0;
            last_ts_q  <= '0;
        end else begin
            run_q      <= run_d;
            first_ts_q <= first_ts_d;
            last_ts_q  <= last_ts_d;
        end
    end

    assign first_ts_o = first_ts_q;

endmodule

// File: rtl/echo_receiver.sv
// Ultrasonic time-of-flight front end: burst gating, ring-down blanking, echo timing.
// Optional macro ECHO_RX_GLITCH_FILTER_EN enables the receiver-pin majority filter.
module echo_receiver
    import echo_rx_pkg::*;
#(
    parameter int unsigned CYCLES_PER_PERIOD = 1250,
    parameter int unsigned BURST_PERIODS     = 8,
    parameter int unsigned BLANK_CYCLES      = 50000,
    parameter int unsigned TIMEOUT_CYCLES    = 1500000,
    parameter int unsigned MIN_EDGES         = 4,
    parameter int unsigned TOF_W             = 24
) (
    input  logic             clk_in,
    input  logic             reset_n,
    input  logic             start,
    input  logic             receiver_pin,
    output logic             transmitter_on,
    output logic             busy,
    output logic             tof_valid,
    output logic             timeout,
    output logic [TOF_W-1:0] tof_cycles
);

    localparam int unsigned      BURST_CYCLES = BURST_PERIODS * CYCLES_PER_PERIOD;
    localparam bit               SKIP_BLANK   = (BURST_CYCLES >= BLANK_CYCLES);
    localparam logic [TOF_W-1:0] BURST_END    = TOF_W'(BURST_CYCLES - 1);
    localparam logic [TOF_W-1:0] BLANK_END    = TOF_W'(BLANK_CYCLES - 1);
    localparam logic [TOF_W-1:0] TIMEOUT_END  = TOF_W'(TIMEOUT_CYCLES - 1);

    if (64'(TIMEOUT_CYCLES) >= (64'd1 << TOF_W)) begin : g_tof_w_check
        $error("echo_receiver: TIMEOUT_CYCLES does not fit in TOF_W bits");
    end
    if (MIN_EDGES < 2) begin : g_min_edges_check
        $error("echo_receiver: MIN_EDGES must be at least 2");
    end
    if ((BLANK_CYCLES >= TIMEOUT_CYCLES) || (BURST_CYCLES >= TIMEOUT_CYCLES)) begin : g_window_check
        $error("echo_receiver: burst and blanking must end before the timeout");
    end

    rx_state_e        state_q, state_d;
    logic [TOF_W-1:0] timer_q, timer_d;
    logic [TOF_W-1:0] tof_cycles_q, tof_cycles_d;
    logic             tx_on_q, busy_q, tof_valid_q, timeout_q;
    logic             tof_valid_d, timeout_d;
    logic             detected_c;
    logic [TOF_W-1:0] first_ts;

    echo_edge_qualifier #(
        .CYCLES_PER_PERIOD (CYCLES_PER_PERIOD),
        .MIN_EDGES         (MIN_EDGES),
        .TOF_W             (TOF_W)
    ) u_qual (
        .clk_in         (clk_in),
        .reset_n        (reset_n),
        .receiver_pin_i (receiver_pin),
        .listen_i       (state_q == S_LISTEN),
        .timer_i        (timer_q),
        .detected_c_o   (detected_c),
        .first_ts_o     (first_ts)
    );

    // Next state; detection takes priority over a simultaneous timeout.
    always_comb begin
        state_d      = state_q;
        timer_d      = (state_q == S_IDLE) ? '0 : timer_q + TOF_W'(1);
        tof_cycles_d = tof_cycles_q;
        tof_valid_d  = 1'b0;
        timeout_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_TX;
            end
            S_TX: begin
                if (timer_q == BURST_END) state_d = SKIP_BLANK ? S_LISTEN : S_BLANK;
            end
            S_BLANK: begin
                if (timer_q == BLANK_END) state_d = S_LISTEN;
            end
            S_LISTEN: begin
                if (detected_c) begin
                    tof_cycles_d = first_ts;
                    tof_valid_d  = 1'b1;
                    state_d      = S_DONE;
                end else if (timer_q == TIMEOUT_END) begin
                    timeout_d = 1'b1;
                    state_d   = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            timer_q      <= '0;
            tof_cycles_q <= '0;
            tx_on_q      <= 1'b0;
            busy_q       <= 1'b0;
            tof_valid_q  <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            tof_cycles_q <= tof_cycles_d;
            tx_on_q      <= (state_d == S_TX);
            busy_q       <= (state_d != S_IDLE);
            tof_valid_q  <= tof_valid_d;
            timeout_q    <= timeout_d;
        end
    end

    assign transmitter_on = tx_on_q;
    assign busy           = busy_q;
    assign tof_valid      = tof_valid_q;
    assign timeout        = timeout_q;
    assign tof_cycles     = tof_cycles_q;

endmodule

// File: tb/tb_echo_receiver.sv
// Bench for echo_receiver: directed and random echo trains against a timeline model.
module tb_echo_receiver;

    localparam int CPP     = 10;
    localparam int BURST   = 2;
    localparam int BLANK   = 40;
    localparam int TMO     = 400;
    localparam int MIN_E   = 4;
    localparam int TOL     = CPP / 8;
    localparam int TX_LEN  = BURST * CPP;
    localparam int LISTEN0 = (TX_LEN >= BLANK) ? TX_LEN : BLANK;
`ifdef ECHO_RX_GLITCH_FILTER_EN
    localparam int LAT  = 5;
    localparam bit FILT = 1'b1;
`else
    localparam int LAT  = 3;
    localparam bit FILT = 1'b0;
`endif

    logic        clk_in = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        receiver_pin = 1'b0;
    logic        transmitter_on, busy, tof_valid, timeout;
    logic [15:0] tof_cycles;

    int n_cmp = 0;
    int n_fail = 0;
    int prev_tof = 0;
    bit lvl [0:511];

    echo_receiver #(
        .CYCLES_PER_PERIOD (CPP),
        .BURST_PERIODS     (BURST),
        .BLANK_CYCLES      (BLANK),
        .TIMEOUT_CYCLES    (TMO),
        .MIN_EDGES         (MIN_E),
        .TOF_W             (16)
    ) dut (
        .clk_in         (clk_in),
        .reset_n        (reset_n),
        .start          (start),
        .receiver_pin   (receiver_pin),
        .transmitter_on (transmitter_on),
        .busy           (busy),
        .tof_valid      (tof_valid),
        .timeout        (timeout),
        .tof_cycles     (tof_cycles)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_lvl();
        foreach (lvl[i]) lvl[i] = 1'b0;
    endtask

    task automatic add_pulse(input int t, input int w);
        for (int k = 0; k < w; k++) if (t + k < 512) lvl[t + k] = 1'b1;
    endtask

    // Pin timeline indexed by timer value; the model derives expectations from it.
    task automatic run_trial(input string name);
        int  ets[$];
        int  run, first, prev, d, done_t, exp_tof;
        bit  det;
        ets = {};
        for (int t = 0; t < 510; t++) begin
            bit rise;
            rise = lvl[t] && (t == 0 || !lvl[t - 1]) && (!FILT || lvl[t + 1]);
            if (rise && t + LAT >= LISTEN0 && t + LAT <= TMO - 1) ets.push_back(t + LAT);
        end
        run = 0; first = 0; prev = 0; det = 1'b0; exp_tof = 0; done_t = TMO;
        foreach (ets[i]) begin
            d = ets[i] - prev - CPP;
            if (d < 0) d = -d;
            if (run > 0 && d <= TOL) run++;
            else begin run = 1; first = ets[i]; end
            prev = ets[i];
            if (run == MIN_E) begin
                det = 1'b1; exp_tof = first; done_t = ets[i] + 1;
                break;
            end
        end

        @(posedge clk_in); #1 start = 1'b1;
        @(posedge clk_in); #1 start = 1'b0; receiver_pin = lvl[0];
        for (int c = 0; c <= done_t + 1; c++) begin
            @(negedge clk_in);
            check($sformatf("%s tx_on t=%0d", name, c), int'(transmitter_on), int'(c < TX_LEN));
            check($sformatf("%s busy t=%0d", name, c), int'(busy), int'(c <= done_t));
            check($sformatf("%s tof_valid t=%0d", name, c), int'(tof_valid), int'(c == done_t && det));
            check($sformatf("%s timeout t=%0d", name, c), int'(timeout), int'(c == done_t && !det));
            check($sformatf("%s tof_cycles t=%0d", name, c), int'(tof_cycles),
                  (c >= done_t && det) ? exp_tof : prev_tof);
            @(posedge clk_in); #1;
            receiver_pin = lvl[c + 1];
            start = (c + 1 == 50);
        end
        if (det) prev_tof = exp_tof;
        start = 1'b0;
        receiver_pin = 1'b0;
        repeat (4) @(posedge clk_in);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        check("reset tx_on", int'(transmitter_on), 0);
        check("reset busy", int'(busy), 0);
        check("reset tof_valid", int'(tof_valid), 0);
        check("reset timeout", int'(timeout), 0);
        check("reset tof_cycles", int'(tof_cycles), 0);
        #1 reset_n = 1'b1;
        repeat (2) @(posedge clk_in);
        #1;

        clear_lvl();
        for (int i = 0; i < 4; i++) add_pulse(100 + 10 * i, 5);
        run_trial("basic");

        clear_lvl();
        add_pulse(10, 5); add_pulse(20, 5);
        run_trial("blank_only");

        clear_lvl();
        add_pulse(100, 5); add_pulse(110, 5); add_pulse(124, 5);
        add_pulse(134, 5); add_pulse(144, 5); add_pulse(154, 5);
        run_trial("restart");

        clear_lvl();
        for (int i = 0; i < 4; i++) add_pulse(36 + 10 * i, 4);
        add_pulse(76, 4);
        run_trial("listen_edge");

        // Asynchronous reset in the middle of the burst.
        @(posedge clk_in); #1 start = 1'b1;
        @(posedge clk_in); #1 start = 1'b0;
        repeat (5) @(posedge clk_in);
        #3;
        check("midtx tx_on before reset", int'(transmitter_on), 1);
        reset_n = 1'b0;
        #1;
        check("midtx tx_on async", int'(transmitter_on), 0);
        check("midtx busy async", int'(busy), 0);
        check("midtx tof_cycles async", int'(tof_cycles), 0);
        prev_tof = 0;
        @(posedge clk_in); #1 reset_n = 1'b1;
        repeat (3) @(negedge clk_in);
        check("post reset busy", int'(busy), 0);
        check("post reset tx_on", int'(transmitter_on), 0);
        @(posedge clk_in); #1;

        clear_lvl();
        for (int i = 0; i < 4; i++) add_pulse(100 + 10 * i, 5);
        run_trial("after_reset");

        for (int r = 0; r < 8; r++) begin
            int t, n;
            clear_lvl();
            t = int'($urandom_range(20, 260));
            n = int'($urandom_range(3, 8));
            for (int k = 0; k < n; k++) begin
                add_pulse(t, int'($urandom_range(3, 4)));
                if ($urandom_range(0, 3) == 0) t += int'($urandom_range(12, 20));
                else t += int'($urandom_range(CPP - TOL - 1, CPP + TOL + 1));
            end
            run_trial($sformatf("rand%0d", r));
        end

`ifdef ECHO_RX_GLITCH_FILTER_EN
        clear_lvl();
        for (int i = 0; i < 4; i++) add_pulse(100 + 10 * i, 3);
        add_pulse(95, 1); add_pulse(105, 1);
        run_trial("glitch");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
